stream_min_max: RTL and testbench
=================================

Name: stream_min_max

Overview:
- Streaming reduction stage directly downstream of the 32-bit signed/unsigned less-than comparator.
- Accepts a packet of words over a valid/ready handshake.
- Tracks the running minimum and maximum in either signed or unsigned order, together with their element indices.
- Presents one result beat per packet on a second valid/ready handshake.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of the element counter and index outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  WIDTH  input word.
- in_last  in  1  marks the final beat of a packet.
- sgn_mode  in  1  1 = signed (two's complement) order, 0 = unsigned order; sampled on the first beat only.
- res_valid  out  1  result beat valid.
- res_ready  in  1  consumer accepts the result.
- res_min  out  WIDTH  smallest element of the packet.
- res_max  out  WIDTH  largest element of the packet.
- res_min_idx  out  CNT_W  index of the first occurrence of the minimum.
- res_max_idx  out  CNT_W  index of the first occurrence of the maximum.
- res_count  out  CNT_W  number of elements in the packet, saturating.
- res_signed  out  1  latched sgn_mode for this packet.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all result registers are 0; res_valid = 0; busy = 0; in_ready = 1.
- Reset mid-packet or mid-result discards everything; the first beat after reset starts a new packet.
- Beat acceptance: a beat is accepted when in_valid & in_ready at a rising edge of clk.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an accepted beat: min = max = in_data; min_idx = max_idx = 0; count = 1; latch sgn_mode.
  - Next state is DONE if in_last, otherwise RUN.
- RUN:
  - in_ready = 1.
  - Each accepted beat has index i = current count.
  - Min update: if in_data < min (strict, in the latched order), min <= in_data and min_idx <= i.
  - Max update: if max < in_data (strict), max <= in_data and max_idx <= i.
  - Ties never update, so the earliest index wins.
  - count <= count + 1, saturating at all-ones. Once saturated, the index used for later updates is also all-ones.
  - On an accepted beat with in_last, go to DONE.
- DONE:
  - in_ready = 0; res_valid = 1.
  - All res_* outputs are stable.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
- Latency: res_valid rises in the cycle after the last beat is accepted.
- Throughput: one beat per cycle.
- No input is taken in DONE, so there is a minimum 1-cycle gap between packets.
- Compare rules:
  - Unsigned order is a plain magnitude compare.
  - Signed order: when the sign bits differ, the operand with MSB = 1 is less; otherwise use the unsigned compare of the low bits.
  - The compare must be correct for all operand pairs, including 0x80000000 vs 0x7FFFFFFF; subtraction-overflow artefacts are not allowed.
- Ports outside their stated condition: res_* are held during RUN, and their value there is not checked; sgn_mode is ignored after the first beat of a packet.

Optional Feature:
- Macro: STREAM_MIN_MAX_SUM_EN.
- Defined:
  - Adds output res_sum, width WIDTH+CNT_W.
  - res_sum accumulates every accepted element, sign-extended when the latched mode is signed and zero-extended otherwise.
  - The accumulator is cleared and loaded on the first beat.
  - Wraps modulo 2^(WIDTH+CNT_W).
  - Valid alongside the other results; reset value 0.
- Undefined: no res_sum port and no accumulator logic; all other behaviour is identical.

Test Plan:
- Unsigned packet: sgn_mode = 0, data 5, 0xFFFFFFFF, 3, 0xFFFFFFFF (last) -> res_min = 3 (idx 2), res_max = 0xFFFFFFFF (idx 1), res_count = 4, res_valid one cycle after the last beat.
- Signed packet: same data with sgn_mode = 1 -> res_min = 0xFFFFFFFF (idx 1), res_max = 5 (idx 0).
- Boundary pair: sgn_mode = 1, data 0x7FFFFFFF, 0x80000000 (last) -> min = 0x80000000 (idx 1), max = 0x7FFFFFFF (idx 0). With sgn_mode = 0 the results are reversed.
- Single-beat packet: in_last on the first beat, data 0x1234 -> min = max = 0x1234, both idx 0, count 1.
- Backpressure: hold res_ready = 0 for 5 cycles while in_valid = 1 -> in_ready stays 0 and outputs are stable. Assert res_ready -> IDLE; the next packet is accepted the following cycle.
- Async reset: assert rstn low mid-packet after 3 beats -> outputs 0 and in_ready = 1 immediately. A new 2-beat packet (9, 1) gives min = 1, max = 9, count = 2. With STREAM_MIN_MAX_SUM_EN defined, res_sum = 10.

Source files
------------

// File: rtl/stream_min_max.sv
// Streaming min/max reduction over valid/ready packets, signed or unsigned order, with first-occurrence indices.
// Optional running sum output enabled by defining STREAM_MIN_MAX_SUM_EN.
module stream_min_max #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    input  logic                   sgn_mode,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_min,
    output logic [WIDTH-1:0]       res_max,
    output logic [CNT_W-1:0]       res_min_idx,
    output logic [CNT_W-1:0]       res_max_idx,
    output logic [CNT_W-1:0]       res_count,
    output logic                   res_signed,
`ifdef STREAM_MIN_MAX_SUM_EN
    output logic [WIDTH+CNT_W-1:0] res_sum,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sgn_q, sgn_d;
    logic             accept;

    // Sign bits differing decide signed order outright; no subtraction, so no overflow artefacts.
    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sgn);
        if (sgn && (a[WIDTH-1] != b[WIDTH-1]))
            return a[WIDTH-1];
        return a < b;
    endfunction

`ifdef STREAM_MIN_MAX_SUM_EN
    logic [WIDTH+CNT_W-1:0] sum_q, sum_d;

    function automatic logic [WIDTH+CNT_W-1:0] extend(input logic [WIDTH-1:0] d, input logic sgn);
        return {{CNT_W{sgn & d[WIDTH-1]}}, d};
    endfunction
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;
        sgn_d     = sgn_q;
`ifdef STREAM_MIN_MAX_SUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    min_d     = in_data;
                    max_d     = in_data;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    count_d   = CNT_W'(1);
                    sgn_d     = sgn_mode;
`ifdef STREAM_MIN_MAX_SUM_EN
                    sum_d     = extend(in_data, sgn_mode);
`endif
                    state_d   = in_last ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    // count_q is the index of this beat; it sticks at all-ones once saturated.
                    if (less_than(in_data, min_q, sgn_q)) begin
                        min_d     = in_data;
                        min_idx_d = count_q;
                    end
                    if (less_than(max_q, in_data, sgn_q)) begin
                        max_d     = in_data;
                        max_idx_d = count_q;
                    end
                    count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
`ifdef STREAM_MIN_MAX_SUM_EN
                    sum_d   = sum_q + extend(in_data, sgn_q);
`endif
                    if (in_last)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            sgn_q     <= 1'b0;
`ifdef STREAM_MIN_MAX_SUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            sgn_q     <= sgn_d;
`ifdef STREAM_MIN_MAX_SUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign in_ready    = (state_q != DONE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign res_min     = min_q;
    assign res_max     = max_q;
    assign res_min_idx = min_idx_q;
    assign res_max_idx = max_idx_q;
    assign res_count   = count_q;
    assign res_signed  = sgn_q;
`ifdef STREAM_MIN_MAX_SUM_EN
    assign res_sum     = sum_q;
`endif

endmodule

// File: tb/tb_stream_min_max.sv
// Directed testbench for stream_min_max; checks res_sum too when STREAM_MIN_MAX_SUM_EN is defined.
module tb_stream_min_max;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int RW    = 2*WIDTH + 3*CNT_W + 1;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   in_valid, in_ready, in_last, sgn_mode;
    logic [WIDTH-1:0]       in_data;
    logic                   res_valid, res_ready, res_signed, busy;
    logic [WIDTH-1:0]       res_min, res_max;
    logic [CNT_W-1:0]       res_min_idx, res_max_idx, res_count;
`ifdef STREAM_MIN_MAX_SUM_EN
    logic [WIDTH+CNT_W-1:0] res_sum;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] pkt[$];
    logic [RW-1:0]    got, exp;
    logic             pre_valid;

    stream_min_max #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .sgn_mode(sgn_mode),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_min(res_min), .res_max(res_max),
        .res_min_idx(res_min_idx), .res_max_idx(res_max_idx),
        .res_count(res_count), .res_signed(res_signed),
`ifdef STREAM_MIN_MAX_SUM_EN
        .res_sum(res_sum),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Drives pkt one beat per cycle; later beats carry the opposite sgn_mode to prove it is latched.
    task automatic send_packet(input logic sgn, input logic finish, output logic pv);
        pv = 1'b0;
        for (int i = 0; i < pkt.size(); i++) begin
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = finish && (i == pkt.size() - 1);
            sgn_mode = (i == 0) ? sgn : ~sgn;
            if (i == pkt.size() - 1) pv = res_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sgn_mode = 1'b0; res_ready = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, res_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got in_ready/res_valid/busy=%b expected 100", {in_ready, res_valid, busy});
        end
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        n_cmp++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_results: got %h expected 0", got);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_unsigned();
        pkt = '{32'd5, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
        send_packet(1'b0, 1'b1, pre_valid);
        n_cmp++;
        if ({pre_valid, res_valid, busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL unsigned_latency: got pre/valid/busy=%b expected 011", {pre_valid, res_valid, busy});
        end
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'd3, 32'hFFFFFFFF, 16'd2, 16'd1, 16'd4, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL unsigned_result: got %h expected %h", got, exp);
        end
`ifdef STREAM_MIN_MAX_SUM_EN
        n_cmp++;
        if (res_sum !== 48'h0002_0000_0006) begin
            n_fail++;
            $display("FAIL unsigned_sum: got %h expected 000200000006", res_sum);
        end
`endif
        consume();
        n_cmp++;
        if ({res_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL unsigned_release: got valid/ready/busy=%b expected 010", {res_valid, in_ready, busy});
        end
        $display("test_unsigned done");
    endtask

    task automatic test_signed();
        pkt = '{32'd5, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF};
        send_packet(1'b1, 1'b1, pre_valid);
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'hFFFFFFFF, 32'd5, 16'd1, 16'd0, 16'd4, 1'b1};
        n_cmp++;
        if (got !== exp || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL signed_result: got %h valid=%b expected %h valid=1", got, res_valid, exp);
        end
`ifdef STREAM_MIN_MAX_SUM_EN
        n_cmp++;
        if (res_sum !== 48'd6) begin
            n_fail++;
            $display("FAIL signed_sum: got %h expected 6", res_sum);
        end
`endif
        consume();
        $display("test_signed done");
    endtask

    task automatic test_boundary();
        pkt = '{32'h7FFFFFFF, 32'h80000000};
        send_packet(1'b1, 1'b1, pre_valid);
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'h80000000, 32'h7FFFFFFF, 16'd1, 16'd0, 16'd2, 1'b1};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL boundary_signed: got %h expected %h", got, exp);
        end
`ifdef STREAM_MIN_MAX_SUM_EN
        n_cmp++;
        if (res_sum !== 48'hFFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL boundary_signed_sum: got %h expected ffffffffffff", res_sum);
        end
`endif
        consume();
        send_packet(1'b0, 1'b1, pre_valid);
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'h7FFFFFFF, 32'h80000000, 16'd0, 16'd1, 16'd2, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL boundary_unsigned: got %h expected %h", got, exp);
        end
`ifdef STREAM_MIN_MAX_SUM_EN
        n_cmp++;
        if (res_sum !== 48'h0000_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL boundary_unsigned_sum: got %h expected 0000ffffffff", res_sum);
        end
`endif
        consume();
        $display("test_boundary done");
    endtask

    task automatic test_single();
        pkt = '{32'h1234};
        send_packet(1'b0, 1'b1, pre_valid);
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'h1234, 32'h1234, 16'd0, 16'd0, 16'd1, 1'b0};
        n_cmp++;
        if (got !== exp || {pre_valid, res_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_beat: got %h pre/valid=%b expected %h pre/valid=01", got, {pre_valid, res_valid}, exp);
        end
        consume();
        $display("test_single done");
    endtask

    task automatic test_ties();
        pkt = '{32'd4, 32'd2, 32'd4, 32'd2};
        send_packet(1'b0, 1'b1, pre_valid);
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'd2, 32'd4, 16'd1, 16'd0, 16'd4, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ties_first_index: got %h expected %h", got, exp);
        end
`ifdef STREAM_MIN_MAX_SUM_EN
        n_cmp++;
        if (res_sum !== 48'd12) begin
            n_fail++;
            $display("FAIL ties_sum: got %h expected 12", res_sum);
        end
`endif
        consume();
        $display("test_ties done");
    endtask

    task automatic test_back_to_back();
        pkt = '{32'hFFFFFFF0, 32'h10};
        send_packet(1'b1, 1'b1, pre_valid);
        exp = {32'hFFFFFFF0, 32'h10, 16'd0, 16'd1, 16'd2, 1'b1};
        in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1; sgn_mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
            n_cmp++;
            if (got !== exp || {in_ready, res_valid} !== 2'b01) begin
                n_fail++;
                $display("FAIL backpressure_hold c%0d: got %h ready/valid=%b expected %h ready/valid=01",
                         c, got, {in_ready, res_valid}, exp);
            end
        end
        consume();
        n_cmp++;
        if ({res_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: got valid/ready=%b expected 01", {res_valid, in_ready});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'h55, 32'h55, 16'd0, 16'd0, 16'd1, 1'b0};
        n_cmp++;
        if (got !== exp || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_next: got %h valid=%b expected %h valid=1", got, res_valid, exp);
        end
        consume();
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        pkt = '{32'd7, 32'd3, 32'd8};
        send_packet(1'b0, 1'b0, pre_valid);
        n_cmp++;
        if ({busy, res_valid, res_min, res_max} !== {1'b1, 1'b0, 32'd3, 32'd8}) begin
            n_fail++;
            $display("FAIL midpacket_state: got busy=%b valid=%b min=%h max=%h expected busy=1 valid=0 min=3 max=8",
                     busy, res_valid, res_min, res_max);
        end
        #2 rstn = 1'b0;
        #1;
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        n_cmp++;
        if (got !== '0 || {in_ready, res_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset: got %h ready/valid/busy=%b expected 0 and 100", got, {in_ready, res_valid, busy});
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        pkt = '{32'd9, 32'd1};
        send_packet(1'b0, 1'b1, pre_valid);
        got = {res_min, res_max, res_min_idx, res_max_idx, res_count, res_signed};
        exp = {32'd1, 32'd9, 16'd1, 16'd0, 16'd2, 1'b0};
        n_cmp++;
        if (got !== exp || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_packet: got %h valid=%b expected %h valid=1", got, res_valid, exp);
        end
`ifdef STREAM_MIN_MAX_SUM_EN
        n_cmp++;
        if (res_sum !== 48'd10) begin
            n_fail++;
            $display("FAIL after_reset_sum: got %h expected 10", res_sum);
        end
`endif
        consume();
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_boundary();
        test_single();
        test_ties();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
